// File: rtl/axis_stream_buffer_pkg.sv
// Shared types and default sizes for the AXI-Stream buffer.
package axis_stream_buffer_pkg;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int DEPTH_DEF      = 1 << ADDR_WIDTH_DEF;

  // Output register state: EMPTY = nothing presented, HOLD = word on m00.
  typedef enum logic {
    EMPTY = 1'b0,
    HOLD  = 1'b1
  } rd_state_t;

  // Stored word layout at the default width: last is the MSB, data the LSBs.
  typedef struct packed {
    logic                        last;
    logic [DATA_WIDTH_DEF/8-1:0] strb;
    logic [DATA_WIDTH_DEF-1:0]   data;
  } entry_t;

endpackage

// File: rtl/axis_buffer_ram.sv
// Simple dual-port storage for the stream buffer: synchronous write,
// combinational read so the addressed word can be captured straight into
// the output register in the same cycle the read pointer selects it.
module axis_buffer_ram
  import axis_stream_buffer_pkg::*;
#(
  parameter int WIDTH      = $bits(entry_t),
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem_q [2**ADDR_WIDTH];

  // Write port; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/axis_stream_buffer.sv
// AXI-Stream circular buffer with a registered output stage.
// Holds up to DEPTH words in RAM plus one word in the output register.
// Optional macro AXIS_BUF_PACKET_MODE_EN selects store-and-forward release;
// without it, words are released as soon as they are stored (cut-through).
module axis_stream_buffer
  import axis_stream_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                    axis_aclk,
  input  logic                    axis_aresetn,
  input  logic [DATA_WIDTH-1:0]   s00_axis_tdata,
  input  logic [DATA_WIDTH/8-1:0] s00_axis_tstrb,
  input  logic                    s00_axis_tvalid,
  input  logic                    s00_axis_tlast,
  output logic                    s00_axis_tready,
  output logic [DATA_WIDTH-1:0]   m00_axis_tdata,
  output logic [DATA_WIDTH/8-1:0] m00_axis_tstrb,
  output logic                    m00_axis_tvalid,
  output logic                    m00_axis_tlast,
  input  logic                    m00_axis_tready,
  output logic [ADDR_WIDTH:0]     level,
  output logic [ADDR_WIDTH:0]     pkt_count
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int DEPTH  = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] LEVEL_FULL = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] CNT_ONE    = (ADDR_WIDTH + 1)'(1);

  typedef struct packed {
    logic              last;
    logic [STRB_W-1:0] strb;
    logic [DATA_WIDTH-1:0] data;
  } word_t;

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   level_q, level_d;
  logic [ADDR_WIDTH:0]   pkt_q, pkt_d;
  rd_state_t             state_q, state_d;
  word_t                 out_q, out_d;
  word_t                 wr_word, rd_word;
  logic [$bits(word_t)-1:0] rd_raw;
  logic push, pop, load, load_ok, pkt_release;
  logic pkt_inc, pkt_dec;

  assign s00_axis_tready = (level_q != LEVEL_FULL);
  assign push            = s00_axis_tvalid && s00_axis_tready;
  assign pop             = (state_q == HOLD) && m00_axis_tready;
  assign wr_word         = {s00_axis_tlast, s00_axis_tstrb, s00_axis_tdata};
  assign rd_word         = word_t'(rd_raw);
  assign load_ok         = (level_q != '0) && pkt_release;

  axis_buffer_ram #(
    .WIDTH      ($bits(word_t)),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk     (axis_aclk),
    .wr_en   (push),
    .wr_addr (wr_ptr_q),
    .wr_data (wr_word),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_raw)
  );

`ifdef AXIS_BUF_PACKET_MODE_EN
  logic in_pkt_q, in_pkt_d;

  // Hold words back until a whole packet is stored, unless one is already
  // streaming out or the RAM is full (an oversize packet must drain).
  assign pkt_release = (pkt_q != '0) || in_pkt_q || (level_q == LEVEL_FULL);

  // Track whether the word last loaded left a packet open.
  always_comb begin
    in_pkt_d = in_pkt_q;
    if (load) begin
      in_pkt_d = !rd_word.last;
    end
  end

  // Open-packet flag register.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      in_pkt_q <= 1'b0;
    end else begin
      in_pkt_q <= in_pkt_d;
    end
  end
`else
  assign pkt_release = 1'b1;
`endif

  // Read FSM: decide when the output register is (re)loaded from RAM.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    out_d   = out_q;
    case (state_q)
      EMPTY: begin
        if (load_ok) begin
          load    = 1'b1;
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (pop) begin
          if (load_ok) begin
            load = 1'b1;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
    if (load) begin
      out_d = rd_word;
    end else if (state_d == EMPTY) begin
      out_d = '0;
    end
  end

  assign pkt_inc = push && s00_axis_tlast;
  assign pkt_dec = load && rd_word.last;

  // Pointer and counter updates; simultaneous increment and decrement cancel.
  always_comb begin
    wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = load ? rd_ptr_q + 1'b1 : rd_ptr_q;
    level_d  = level_q;
    pkt_d    = pkt_q;
    if (push && !load) begin
      level_d = level_q + CNT_ONE;
    end else if (!push && load) begin
      level_d = level_q - CNT_ONE;
    end
    if (pkt_inc && !pkt_dec) begin
      pkt_d = pkt_q + CNT_ONE;
    end else if (!pkt_inc && pkt_dec) begin
      pkt_d = pkt_q - CNT_ONE;
    end
  end

  // State registers; reset discards everything including the held word.
  always_ff @(posedge axis_aclk or negedge axis_aresetn) begin
    if (!axis_aresetn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      pkt_q    <= '0;
      state_q  <= EMPTY;
      out_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      pkt_q    <= pkt_d;
      state_q  <= state_d;
      out_q    <= out_d;
    end
  end

  assign m00_axis_tvalid = (state_q == HOLD);
  assign m00_axis_tdata  = out_q.data;
  assign m00_axis_tstrb  = out_q.strb;
  assign m00_axis_tlast  = out_q.last;
  assign level           = level_q;
  assign pkt_count       = pkt_q;

endmodule
